mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit on the operand outputs of the 32-entry register file.
- Accepts two N-bit source operands, a funct3 opcode and a destination register index.
- Computes the result over N iterations, then presents data, write index and write enable in the form the register file's write port (D / WriteReg / RegWrite) consumes.
- The core stalls on `busy` while an operation is in flight.

---
 rtl/mdu_iter_pkg.sv | 25 ++
 rtl/mdu_iter_twos_abs.sv | 16 +
 rtl/mdu_iter.sv | 181 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 encodings,
// FSM state encoding and iteration-counter sizing.
package mdu_iter_pkg;

  localparam logic [2:0] MduMul    = 3'b000;
  localparam logic [2:0] MduMulh   = 3'b001;
  localparam logic [2:0] MduMulhsu = 3'b010;
  localparam logic [2:0] MduMulhu  = 3'b011;
  localparam logic [2:0] MduDiv    = 3'b100;
  localparam logic [2:0] MduDivu   = 3'b101;
  localparam logic [2:0] MduRem    = 3'b110;
  localparam logic [2:0] MduRemu   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mdu_iter_twos_abs.sv
// Two's-complement magnitude and sign extraction for one operand.
module twos_abs #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] value,
  input  logic         signed_mode,
  output logic [N-1:0] mag,
  output logic         sgn
);

  always_comb begin
    sgn = signed_mode & value[N-1];
    mag = sgn ? (~value + N'(1)) : value;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with results shaped for the register-file write port.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  input  logic [4:0]   rd_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [4:0]   rd_out,
  output logic         reg_write
);

  localparam int unsigned CntW = cnt_width(N);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d, rd_out_q, rd_out_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*N-1:0]      acc_q, acc_d;
  logic [N-1:0]        opb_q, opb_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic [N-1:0]        result_q, result_d;

  logic                a_signed, b_signed, a_sgn, b_sgn;
  logic [N-1:0]        a_mag, b_mag;
  logic                div_zero, div_ovf;
  logic [N-1:0]        special_res;
  logic [N:0]          mul_sum, div_top, div_diff;
  logic [2*N-1:0]      mul_next, div_next;

  assign a_signed = op inside {MduMulh, MduMulhsu, MduDiv, MduRem};
  assign b_signed = op inside {MduMulh, MduDiv, MduRem};

  twos_abs #(.N(N)) u_abs_a (
    .value       (rs1_data),
    .signed_mode (a_signed),
    .mag         (a_mag),
    .sgn         (a_sgn)
  );

  twos_abs #(.N(N)) u_abs_b (
    .value       (rs2_data),
    .signed_mode (b_signed),
    .mag         (b_mag),
    .sgn         (b_sgn)
  );

  assign div_zero = (rs2_data == '0);
  assign div_ovf  = (op == MduDiv || op == MduRem) && (rs1_data == {1'b1, {(N-1){1'b0}}})
                    && (rs2_data == '1);

  // op[1] separates REM* from DIV* once op[2] is known to be set.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? rs1_data : '1;
    end else begin
      special_res = op[1] ? '0 : rs1_data;
    end
  end

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set.
  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[N-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts in quotient bits.
  assign div_top  = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_diff = div_top - {1'b0, opb_q};
  assign div_next = div_diff[N] ? {div_top[N-1:0], acc_q[N-2:0], 1'b0}
                                : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};

  function automatic logic [N-1:0] fixup(input logic [2*N-1:0] acc, input logic [2:0] fop,
                                         input logic neg, input logic rneg);
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    prod  = neg ? (~acc + (2*N)'(1)) : acc;
    quo   = neg ? (~acc[N-1:0] + N'(1)) : acc[N-1:0];
    rem   = rneg ? (~acc[2*N-1:N] + N'(1)) : acc[2*N-1:N];
    fixup = prod[N-1:0];
    unique case (fop)
      MduMul:                       fixup = prod[N-1:0];
      MduMulh, MduMulhsu, MduMulhu: fixup = prod[2*N-1:N];
      MduDiv, MduDivu:              fixup = quo;
      MduRem, MduRemu:              fixup = rem;
      default:                      fixup = prod[N-1:0];
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (start) begin
          op_d   = op;
          rd_d   = rd_in;
          cnt_d  = '0;
          neg_d  = a_sgn ^ b_sgn;
          rneg_d = a_sgn;
          if (!op[2]) begin
            state_d = StMul;
            acc_d   = {{N{1'b0}}, b_mag};
            opb_d   = a_mag;
          end else if (div_zero || div_ovf) begin
            state_d  = StDone;
            result_d = special_res;
            rd_out_d = rd_in;
          end else begin
            state_d = StDiv;
            acc_d   = {{N{1'b0}}, a_mag};
            opb_d   = b_mag;
          end
        end
      end
      StMul, StDiv: begin
        acc_d = (state_q == StMul) ? mul_next : div_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d  = StDone;
          result_d = fixup(acc_d, op_q, neg_q, rneg_q);
          rd_out_d = rd_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign rd_out    = rd_out_q;
  assign reg_write = done && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic results, latency, special divides,
// ignored start, mid-operation reset, rd=0 and back-to-back issue.
module tb_mdu_iter;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [N-1:0]  rs1_data = '0;
  logic [N-1:0]  rs2_data = '0;
  logic [4:0]    rd_in = '0;
  logic          busy, done, reg_write;
  logic [N-1:0]  result;
  logic [4:0]    rd_out;

  int n_chk  = 0;
  int n_pass = 0;

  mdu_iter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Present a request, let the next rising edge take it, then scramble the inputs.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = 32'hA5A5_5A5A; rs2_data = 32'h0F0F_F0F0;
    op = ~o; rd_in = ~rd;
  endtask

  // Called in cycle first_cyc after the start edge; follows the op until done.
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd,
                           input int exp_lat, input int first_cyc);
    int cyc = first_cyc;
    int busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - first_cyc));
    check({tag, "/result"}, result, exp_res);
    check({tag, "/rd_out"}, 32'(rd_out), 32'(exp_rd));
    check({tag, "/reg_write"}, 32'(reg_write), 32'(exp_rd != 5'd0));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                     input int exp_lat);
    @(negedge clk);
    launch(o, a, b, rd);
    wait_done(tag, exp_res, rd, exp_lat, 1);
  endtask

  initial begin
    int done_cnt;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/result", result, 32'd0);
    check("rst/rd_out", 32'(rd_out), 32'd0);
    check("rst/reg_write", 32'(reg_write), 32'd0);
    @(negedge clk) rst = 1'b1;

    run("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    @(posedge clk); #1;
    check("mul/done_pulse", 32'(done), 32'd0);
    check("mul/result_hold", result, 32'hFFFF_FFEB);

    run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 33);
    run("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 33);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33);
    run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
    run("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    run("remu", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 33);

    run("divu_by0", 3'b101, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    run("remu_by0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);

    // Second start while busy must not disturb the running DIVU.
    @(negedge clk);
    launch(3'b101, 32'd100, 32'd7, 5'd9);
    repeat (3) @(posedge clk);
    #1;
    op = 3'b101; rs1_data = 32'd200; rs2_data = 32'd3; rd_in = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start", 32'd14, 5'd9, 33, 5);

    // Reset in the middle of an operation.
    @(negedge clk);
    launch(3'b101, 32'd100, 32'd3, 5'd4);
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/result", result, 32'd0);
    check("abort/rd_out", 32'(rd_out), 32'd0);
    check("abort/reg_write", 32'(reg_write), 32'd0);
    @(negedge clk) rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort/no_done", 32'(done_cnt), 32'd0);

    run("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12, 33);

    // rd=0 suppresses the write; a start in the DONE cycle is taken immediately.
    run("mul_rd0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 33);
    launch(3'b101, 32'd100, 32'd7, 5'd3);
    check("b2b/done_low", 32'(done), 32'd0);
    check("b2b/busy_high", 32'(busy), 32'd1);
    wait_done("b2b", 32'd14, 5'd3, 33, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
